// File: rtl/rob_alloc_if.sv
// Decoder <-> ROB allocator bus: group allocation handshake, commit/flush
// controls and the allocator's pointer/status view.
interface rob_alloc_if #(
    parameter int WIDTH = 4,
    parameter int PTR_W = 5
);
    logic                   alloc_valid;
    logic [2:0]             alloc_count;
    logic                   alloc_ready;
    logic [WIDTH*PTR_W-1:0] alloc_entries;
    logic [2:0]             commit_count;
    logic                   flush;
    logic [PTR_W-1:0]       head_ptr;
    logic [PTR_W-1:0]       tail_ptr;
    logic [PTR_W:0]         occupancy;
    logic                   empty;
    logic                   full;
    logic                   err;

    modport master (
        output alloc_valid, alloc_count, commit_count, flush,
        input  alloc_ready, alloc_entries, head_ptr, tail_ptr, occupancy, empty, full, err
    );

    modport slave (
        input  alloc_valid, alloc_count, commit_count, flush,
        output alloc_ready, alloc_entries, head_ptr, tail_ptr, occupancy, empty, full, err
    );
endinterface

// File: rtl/rob_allocator.sv
// Reorder-buffer allocator: circular head/tail pointers with group allocation,
// in-order group commit, one-cycle flush state and a sticky protocol error flag.
module rob_allocator #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 32,
    parameter int PTR_W = 5
) (
    input  logic         clk,
    input  logic         rst,
    rob_alloc_if.slave   bus
);
    typedef enum logic {RUN, FLUSH} state_t;

    localparam logic [PTR_W+1:0] DEPTH_EXT = (PTR_W+2)'(DEPTH);
    localparam logic [PTR_W+1:0] WIDTH_EXT = (PTR_W+2)'(WIDTH);

    state_t           r_state;
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [PTR_W:0]   r_occ;
    logic             r_err;

    logic [PTR_W+1:0] w_allocExt;
    logic [PTR_W+1:0] w_commitExt;
    logic [PTR_W+1:0] w_occExt;
    logic [PTR_W+1:0] w_free;
    logic [PTR_W+1:0] w_allocStep;
    logic [PTR_W+1:0] w_commitN;
    logic [PTR_W+1:0] w_occNext;
    logic             w_allocOk;
    logic             w_fire;
    logic             w_errSet;

    // All occupancy arithmetic is done two bits wider than the pointers so nothing wraps.
    assign w_allocExt  = {{(PTR_W-1){1'b0}}, bus.alloc_count};
    assign w_commitExt = {{(PTR_W-1){1'b0}}, bus.commit_count};
    assign w_occExt    = {1'b0, r_occ};
    assign w_free      = DEPTH_EXT - w_occExt;
    assign w_allocOk   = (w_allocExt <= WIDTH_EXT);

    // Ready uses only registered occupancy; a commit this cycle gives no credit.
    assign bus.alloc_ready = !rst && (r_state == RUN) && w_allocOk && (w_free >= w_allocExt);

    assign w_fire      = bus.alloc_valid && bus.alloc_ready && !bus.flush;
    assign w_allocStep = w_fire ? w_allocExt : '0;

    always_comb begin
        w_commitN = w_commitExt;
        if (w_commitN > w_occExt) w_commitN = w_occExt;
        if (w_commitN > WIDTH_EXT) w_commitN = WIDTH_EXT;
    end

    assign w_occNext = w_occExt + w_allocStep - w_commitN;

    // A flush cycle's commit cannot raise err; an oversized alloc request always can.
    assign w_errSet = (bus.alloc_valid && !w_allocOk)
                    || (!bus.flush && ((w_commitExt > w_occExt) || (w_commitExt > WIDTH_EXT)))
                    || w_occNext[PTR_W+1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= RUN;
            r_head  <= '0;
            r_tail  <= '0;
            r_occ   <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_errSet) r_err <= 1'b1;
            if (bus.flush) begin
                r_state <= FLUSH;
                r_head  <= r_tail;
                r_occ   <= '0;
            end else begin
                r_state <= RUN;
                r_tail  <= r_tail + w_allocStep[PTR_W-1:0];
                r_head  <= r_head + w_commitN[PTR_W-1:0];
                r_occ   <= w_occNext[PTR_W:0];
            end
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_entries
        assign bus.alloc_entries[PTR_W*i +: PTR_W] = r_tail + PTR_W'(i);
    end

    assign bus.head_ptr  = r_head;
    assign bus.tail_ptr  = r_tail;
    assign bus.occupancy = r_occ;
    assign bus.empty     = (r_occ == '0);
    assign bus.full      = (w_occExt == DEPTH_EXT);
    assign bus.err       = r_err;
endmodule

// File: tb/tb_rob_allocator.sv
// Self-checking bench for rob_allocator: directed corner cases plus randomized
// traffic compared against an integer-arithmetic model of the ROB.
module tb_rob_allocator;
    localparam int WIDTH = 4;
    localparam int DEPTH = 32;
    localparam int PTR_W = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;

    rob_alloc_if #(.WIDTH(WIDTH), .PTR_W(PTR_W)) bus ();

    rob_allocator #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int testsRun = 0;
    int testsFailed = 0;

    // Reference model: plain integer ROB bookkeeping.
    int  mHead, mTail, mOcc;
    bit  mErr, mInFlush;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        testsRun++;
        if (observed != expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        mHead = 0; mTail = 0; mOcc = 0; mErr = 0; mInFlush = 0;
    endtask

    function automatic bit modelReady(input int cnt);
        return !mInFlush && cnt <= WIDTH && (DEPTH - mOcc) >= cnt;
    endfunction

    task automatic checkState(input string where);
        checkOutput({where, ".head"}, int'(bus.head_ptr), mHead);
        checkOutput({where, ".tail"}, int'(bus.tail_ptr), mTail);
        checkOutput({where, ".occ"}, int'(bus.occupancy), mOcc);
        checkOutput({where, ".empty"}, int'(bus.empty), int'(mOcc == 0));
        checkOutput({where, ".full"}, int'(bus.full), int'(mOcc == DEPTH));
        checkOutput({where, ".err"}, int'(bus.err), int'(mErr));
    endtask

    // One clock of stimulus: drive at negedge, check combinational outputs, then state after the edge.
    task automatic applyStimulus(input bit v, input int cnt, input int cc, input bit fl);
        int  cn;
        bit  fire;
        logic [WIDTH*PTR_W-1:0] ent;
        @(negedge clk);
        bus.alloc_valid  = v;
        bus.alloc_count  = 3'(cnt);
        bus.commit_count = 3'(cc);
        bus.flush        = fl;
        #1;
        checkOutput("ready", int'(bus.alloc_ready), int'(modelReady(cnt)));
        ent = bus.alloc_entries;
        for (int i = 0; i < WIDTH; i++)
            checkOutput($sformatf("entry%0d", i), int'(ent[PTR_W*i +: PTR_W]), (mTail + i) % DEPTH);
        fire = v && modelReady(cnt) && !fl;
        if (v && cnt > WIDTH) mErr = 1;
        if (fl) begin
            mHead = mTail;
            mOcc = 0;
            mInFlush = 1;
        end else begin
            if (cc > mOcc || cc > WIDTH) mErr = 1;
            cn = cc;
            if (cn > mOcc) cn = mOcc;
            if (cn > WIDTH) cn = WIDTH;
            mTail = (mTail + (fire ? cnt : 0)) % DEPTH;
            mHead = (mHead + cn) % DEPTH;
            mOcc = mOcc + (fire ? cnt : 0) - cn;
            mInFlush = 0;
        end
        @(posedge clk);
        #1;
        checkState("post");
    endtask

    task automatic doReset();
        @(negedge clk);
        #2;
        rst = 1'b1;
        bus.alloc_valid = 1'b1;
        bus.alloc_count = 3'd1;
        bus.commit_count = 3'd0;
        bus.flush = 1'b0;
        #1;
        modelReset();
        checkState("rst");
        checkOutput("rst.ready", int'(bus.alloc_ready), 0);
        for (int i = 0; i < WIDTH; i++)
            checkOutput($sformatf("rst.entry%0d", i), int'(bus.alloc_entries[PTR_W*i +: PTR_W]), i);
        @(negedge clk);
        rst = 1'b0;
        bus.alloc_valid = 1'b0;
    endtask

    initial begin
        bus.alloc_valid = 1'b0;
        bus.alloc_count = 3'd0;
        bus.commit_count = 3'd0;
        bus.flush = 1'b0;
        modelReset();

        // Fill to full, then the 9th request is refused.
        doReset();
        for (int i = 0; i < 8; i++) applyStimulus(1, 4, 0, 0);
        checkOutput("fill.full", int'(bus.full), 1);
        checkOutput("fill.tail", int'(bus.tail_ptr), 0);
        applyStimulus(1, 1, 0, 0);

        // Full with simultaneous commit: no credit, then alloc fires next cycle.
        applyStimulus(1, 4, 4, 0);
        checkOutput("fullCommit.occ", int'(bus.occupancy), 28);
        checkOutput("fullCommit.head", int'(bus.head_ptr), 4);
        applyStimulus(1, 4, 0, 0);
        checkOutput("fullCommit.refill", int'(bus.occupancy), 32);

        // Pointer wrap from head=tail=30.
        doReset();
        for (int i = 0; i < 7; i++) applyStimulus(1, 4, 0, 0);
        applyStimulus(1, 2, 0, 0);
        applyStimulus(0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0);
        applyStimulus(1, 4, 0, 0);
        checkOutput("wrap.tail", int'(bus.tail_ptr), 2);
        checkOutput("wrap.occ", int'(bus.occupancy), 4);

        // Flush overrides alloc and commit; one dead cycle afterwards.
        doReset();
        applyStimulus(1, 4, 0, 0);
        applyStimulus(1, 4, 0, 0);
        applyStimulus(1, 2, 0, 0);
        applyStimulus(1, 3, 2, 1);
        checkOutput("flush.occ", int'(bus.occupancy), 0);
        checkOutput("flush.head", int'(bus.head_ptr), 10);
        applyStimulus(1, 3, 0, 0);
        applyStimulus(1, 3, 0, 0);
        checkOutput("flush.err", int'(bus.err), 0);

        // Over-commit clamps and sets sticky err.
        doReset();
        applyStimulus(1, 1, 0, 0);
        applyStimulus(0, 0, 3, 0);
        checkOutput("overCommit.err", int'(bus.err), 1);
        applyStimulus(1, 2, 0, 0);
        applyStimulus(0, 0, 0, 1);
        checkOutput("overCommit.sticky", int'(bus.err), 1);

        // Oversized alloc request.
        doReset();
        applyStimulus(1, 6, 0, 0);
        checkOutput("bigAlloc.err", int'(bus.err), 1);

        // Legal random traffic, then a mid-cycle reset, then traffic including violations.
        doReset();
        for (int n = 0; n < 400; n++) begin
            int cc;
            cc = $urandom_range(0, (mOcc < WIDTH) ? mOcc : WIDTH);
            applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, WIDTH), cc, $urandom_range(0, 31) == 0);
        end
        checkOutput("random.errClean", int'(bus.err), 0);
        doReset();
        for (int n = 0; n < 300; n++)
            applyStimulus($urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 15) == 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL timeout: got running expected finished");
        $fatal(1, "[TB] timeout");
    end
endmodule

// File: doc/rob_allocator.md
ROB_ALLOCATOR -- requirements
Module: rob_allocator

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the maximum entries allocated or committed per cycle.
REQ-002 The block SHALL have parameter DEPTH, default 32, giving the number of ROB entries; DEPTH SHALL be a power of two.
REQ-003 The block SHALL have parameter PTR_W, default 5, equal to log2(DEPTH).
REQ-004 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 alloc_valid  in  1  decoder requests a group allocation this cycle.
REQ-007 alloc_count  in  3  number of entries requested, 0..WIDTH.
REQ-008 alloc_ready  out  1  group allocation accepted when high together with alloc_valid.
REQ-009 alloc_entries  out  WIDTH*PTR_W  slot i at [PTR_W*i +: PTR_W] = (tail+i) mod DEPTH, driven for every slot regardless of alloc_count.
REQ-010 commit_count  in  3  entries retired in order from head this cycle, 0..WIDTH.
REQ-011 flush  in  1  discard all in-flight entries.
REQ-012 head_ptr  out  PTR_W  oldest live entry.
REQ-013 tail_ptr  out  PTR_W  next entry to allocate.
REQ-014 occupancy  out  PTR_W+1  live entries, 0..DEPTH.
REQ-015 empty, full  out  1 each  occupancy==0, occupancy==DEPTH.
REQ-016 err  out  1  sticky protocol-violation flag.

Function
REQ-017 The block SHALL implement a two-state FSM: RUN and FLUSH.
REQ-018 fire = alloc_valid & alloc_ready; a fire with alloc_count==0 SHALL be legal and SHALL change no state.
REQ-019 alloc_ready SHALL be high only in RUN, with alloc_count <= WIDTH and (DEPTH - occupancy) >= alloc_count, using registered occupancy (no same-cycle commit credit).
REQ-020 alloc_ready SHALL NOT depend combinationally on alloc_valid.
REQ-021 On fire, tail SHALL advance by alloc_count mod DEPTH on the next edge.
REQ-022 commit_n = min(commit_count, occupancy, WIDTH); head SHALL advance by commit_n mod DEPTH.
REQ-023 err SHALL be set if commit_count > occupancy or commit_count > WIDTH, or if alloc_valid is high with alloc_count > WIDTH; err SHALL clear only on reset.
REQ-024 occupancy_next SHALL equal occupancy + (fire ? alloc_count : 0) - commit_n, computed at PTR_W+2 bits with no wrap.
REQ-025 Simultaneous alloc and commit SHALL both take effect in the same cycle.
REQ-026 A commit SHALL be honoured even when full.
REQ-027 flush in either state: next head = tail = current tail, occupancy = 0, state = FLUSH; flush SHALL override alloc and commit that cycle (no fire counted, commit ignored, err not set by that cycle's commit).
REQ-028 FLUSH SHALL last exactly one cycle with alloc_ready low, then return to RUN unless flush is reasserted.
REQ-029 Pointer wrap: e.g. tail=30 with alloc_count=4 SHALL give entries 30,31,0,1 and next tail=2.
REQ-030 All outputs except alloc_ready SHALL be registered state or a direct decode of it.

Reset
REQ-031 While rst is high: head_ptr=0, tail_ptr=0, occupancy=0, empty=1, full=0, err=0, state=RUN; alloc_entries = 0,1,..,WIDTH-1.
REQ-032 alloc_ready SHALL be low while rst is high.
REQ-033 Reset asserted mid-operation SHALL discard all state immediately, without waiting for a clock edge.

Verification
REQ-034 After reset, 8 cycles of alloc_valid=1, alloc_count=4, commit_count=0 -> all fire, occupancy=32, full=1, tail=0; the 9th request (count 1) -> alloc_ready=0.
REQ-035 full, then commit_count=4 with alloc_count=4 in the same cycle -> alloc_ready=0 that cycle; next cycle occupancy=28, head=4, then alloc fires.
REQ-036 head=tail=30, occupancy=0, alloc_count=4 -> alloc_entries={30,31,0,1}, tail=2, occupancy=4.
REQ-037 occupancy=10, flush=1 with alloc_valid=1, count=3, commit_count=2 -> next occupancy=0, head=tail=old tail, alloc_ready=0 for one cycle, then 1.
REQ-038 occupancy=1, commit_count=3 -> occupancy=0, head+=1, err=1 and err stays 1 until rst.
REQ-039 rst pulse asserted between clock edges mid-stream -> outputs return to reset values before the next edge.
